// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial datapath blocks.
//   ST_W                       : state register width
//   ST_IDLE / ST_SHIFT / ST_DONE : state codes (2'b11 is unused)
//   state_e                    : enum over the state codes
//   half_add()                 : half-adder primitive, returns {carry, sum}
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'b01;
  localparam logic [ST_W-1:0] ST_DONE  = 2'b10;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

  // Half-adder primitive: {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Combinational one-bit full adder built from two half-adder stages; the
// final carry is the OR of the two stage carries (they can never both be 1).
// Ports:
//   x, y : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module full_adder_cell
  import serial_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic [1:0] ha0;
  logic [1:0] ha1;

  assign ha0 = half_add(x, y);
  assign ha1 = half_add(ha0[0], ci);
  assign s   = ha1[0];
  assign co  = ha0[1] | ha1[1];

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// with a registered carry and a single full-adder cell.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf.
// Handshake: start is sampled only in IDLE; the accepting edge captures a, b
// and cin. busy is high for the WIDTH SHIFT cycles, then done pulses for one
// cycle with sum/cout valid. sum/cout hold until the next accepted start.
// start seen in SHIFT or DONE is dropped, never queued.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, a, b, cin: request and operands
//   busy, done      : status
//   sum, cout       : registered result and final carry
//   ovf             : signed overflow (only with SERIAL_ADDER_OVF_EN)
//   dbg_state       : current FSM state code, for observation only
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic [ST_W-1:0]  dbg_state,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic s_bit;
  logic c_next;
  logic last_bit;

  full_adder_cell u_fa (
    .x  (ra_q[0]),
    .y  (rb_q[0]),
    .ci (c_q),
    .s  (s_bit),
    .co (c_next)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at sum[0].
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = s_bit;
        ra_d             = ra_q >> 1;
        rb_d             = rb_q >> 1;
        c_d              = c_next;
        cnt_d            = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cout_d  = c_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // On the MSB step c_q is the carry into the MSB, c_next the carry out.
          ovf_d   = c_q ^ c_next;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        // Unused code 2'b11: recover to IDLE.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
